// File: rtl/model_lstm_pkg.sv
// Shared types and helpers for the LSTM input-vector feeder.
// Holds the feeder FSM state encoding, the zero data word and the address-width helper.
package model_lstm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        END   = 2'd3
    } state_t;

    localparam logic [63:0] ZERO_DATA = 64'd0;

    // Width needed to count 0..depth inclusive (write count reaches depth when full).
    function automatic int addr_size(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/model_lstm_vector_feeder_if.sv
// Host-load, run-control and element-stream signals of the vector feeder.
// The feeder uses the slave view; the host/consumer side uses the master view.
interface model_lstm_vector_feeder_if #(
    parameter int DATA_SIZE = 64
);

    logic                 LOAD_ENABLE;
    logic [DATA_SIZE-1:0] LOAD_DATA;
    logic                 CLEAR;
    logic                 LOAD_FULL;
    logic [DATA_SIZE-1:0] SIZE_IN;
    logic                 START;
    logic                 READY;
    logic                 DONE;
    logic                 ERROR;
    logic                 X_IN_ENABLE;
    logic [DATA_SIZE-1:0] X_IN;
    logic                 X_OUT_ENABLE;

    modport master (
        output LOAD_ENABLE, LOAD_DATA, CLEAR, SIZE_IN, START, X_OUT_ENABLE,
        input  LOAD_FULL, READY, DONE, ERROR, X_IN_ENABLE, X_IN
    );

    modport slave (
        input  LOAD_ENABLE, LOAD_DATA, CLEAR, SIZE_IN, START, X_OUT_ENABLE,
        output LOAD_FULL, READY, DONE, ERROR, X_IN_ENABLE, X_IN
    );

endinterface

// File: rtl/model_lstm_feeder_ram.sv
// Vector buffer: DEPTH x DATA_SIZE, one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset so a loaded vector survives for replay.
module model_lstm_feeder_ram #(
    parameter  int DATA_SIZE = 64,
    parameter  int DEPTH     = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/model_lstm_vector_feeder.sv
// Upstream feeder for the LSTM controller X_IN channel: buffers one host-written vector
// and streams SIZE_IN elements per START with a strobe/acknowledge element handshake.
module model_lstm_vector_feeder
    import model_lstm_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int DEPTH        = 64
) (
    input  logic                          CLK,
    input  logic                          RST,
    model_lstm_vector_feeder_if.slave     bus
);

    localparam int ADDR_SIZE = addr_size(DEPTH);
    localparam int AW        = $clog2(DEPTH);

    if (DEPTH < 2 || CONTROL_SIZE < 1) begin : g_bad_params
        $error("model_lstm_vector_feeder: DEPTH must be >= 2 and CONTROL_SIZE >= 1");
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_SIZE-1:0]   r_wr_cnt;
    logic [ADDR_SIZE-1:0]   w_wr_cnt_nxt;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW-1:0]          r_last;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_error;
    logic                   r_x_in_en;
    logic [DATA_SIZE-1:0]   r_x_in;
    logic                   r_load_full;

    logic                   w_in_idle;
    logic                   w_full;
    logic                   w_wr;
    logic                   w_start_bad;
    logic                   w_start_acc;
    logic                   w_start_rej;
    logic                   w_ack;
    logic                   w_last;
    logic [DATA_SIZE-1:0]   w_rd_data;

    assign w_in_idle   = (r_state == IDLE);
    assign w_full      = (r_wr_cnt == ADDR_SIZE'(DEPTH));
    assign w_wr        = w_in_idle && bus.LOAD_ENABLE && !bus.CLEAR && !w_full;
    // Length check is against the count before any same-cycle write lands.
    assign w_start_bad = (bus.SIZE_IN == '0) || (bus.SIZE_IN > DATA_SIZE'(r_wr_cnt));
    assign w_start_acc = w_in_idle && bus.START && !w_start_bad;
    assign w_start_rej = w_in_idle && bus.START && w_start_bad;
    assign w_ack       = (r_state == WAIT) && bus.X_OUT_ENABLE;
    assign w_last      = (r_rd_ptr == r_last);

    model_lstm_feeder_ram #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_wr),
        .i_waddr (r_wr_cnt[AW-1:0]),
        .i_wdata (bus.LOAD_DATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_wr_cnt_nxt = r_wr_cnt;
        if (w_in_idle && bus.CLEAR) begin
            w_wr_cnt_nxt = '0;
        end else if (w_wr) begin
            w_wr_cnt_nxt = r_wr_cnt + ADDR_SIZE'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_acc) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_ack) w_next_state = w_last ? END : ISSUE;
            END:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_last      <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_x_in_en   <= 1'b0;
            r_x_in      <= DATA_SIZE'(ZERO_DATA);
            r_load_full <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_load_full <= (w_wr_cnt_nxt == ADDR_SIZE'(DEPTH));
            r_error     <= w_start_rej;
            r_done      <= w_ack && w_last;
            r_x_in_en   <= (r_state == ISSUE);
            if (r_state == ISSUE) begin
                r_x_in <= w_rd_data;
            end
            if (w_start_acc) begin
                r_ready  <= 1'b0;
                r_rd_ptr <= '0;
                r_last   <= AW'(bus.SIZE_IN - DATA_SIZE'(1));
            end else if (r_state == END) begin
                r_ready  <= 1'b1;
            end
            if (w_ack && !w_last) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    assign bus.READY       = r_ready;
    assign bus.DONE        = r_done;
    assign bus.ERROR       = r_error;
    assign bus.X_IN_ENABLE = r_x_in_en;
    assign bus.X_IN        = r_x_in;
    assign bus.LOAD_FULL   = r_load_full;

endmodule
